// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA sync path: default 640x480@60 geometry,
// counter width and sync polarity.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam logic SYNC_POL_DEF = 1'b0;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic sync_level(input logic in_sync, input logic pol);
        return in_sync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus combinational decode of
// the active and sync regions for the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic cin_i,
    output cnt_t count_o,
    output logic carry_o,
    output logic in_active_o,
    output logic in_sync_o
);

    localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
    localparam int SYNC_FIRST = ACTIVE + FP;
    localparam int SYNC_LAST  = ACTIVE + FP + SYNC - 1;

    generate
        if (TOTAL > (1 << CNT_W) || TOTAL < 1) begin : g_bad_total
            $error("vga_axis_counter: total %0d does not fit a %0d-bit counter", TOTAL, CNT_W);
        end
    endgenerate

    cnt_t count_q, count_d;

    // Carry marks the last position of the axis; the wrap happens on the next enabled step.
    assign carry_o = cin_i && (count_q == cnt_t'(TOTAL - 1));

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i && cin_i) begin
            count_d = carry_o ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign in_active_o = int'(count_q) < ACTIVE;
    assign in_sync_o   = (int'(count_q) >= SYNC_FIRST) && (int'(count_q) <= SYNC_LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// VGA sync generator: horizontal/vertical counters advanced by the pixel tick,
// with registered sync, blanking, coordinate and line/frame-start outputs.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = SYNC_POL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start
);

    cnt_t h_cnt, v_cnt;
    logic h_carry, h_active, h_sync, v_active, v_sync;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (pix_en),
        .cin_i      (1'b1),
        .count_o    (h_cnt),
        .carry_o    (h_carry),
        .in_active_o(h_active),
        .in_sync_o  (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (pix_en && h_carry),
        .cin_i      (1'b1),
        .count_o    (v_cnt),
        .carry_o    (),
        .in_active_o(v_active),
        .in_sync_o  (v_sync)
    );

    logic hsync_q, hsync_d, vsync_q, vsync_d, video_on_q, video_on_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;
    cnt_t pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

    // Level outputs load the pre-increment decode on a tick and hold otherwise;
    // the start pulses are recomputed every clk so they never outlast one cycle.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        line_start_d  = pix_en && (h_cnt == '0);
        frame_start_d = pix_en && (h_cnt == '0) && (v_cnt == '0);
        if (pix_en) begin
            hsync_d    = sync_level(h_sync, SYNC_POL);
            vsync_d    = sync_level(v_sync, SYNC_POL);
            video_on_d = h_active && v_active;
            pixel_x_d  = h_cnt;
            pixel_y_d  = v_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/vga_sync_generator.md
Name: vga_sync_generator

Overview:
- Consumes the single-cycle pixel-enable tick from the 25 MHz clock-enable generator; runs on the system clock `clk`.
- Advances horizontal and vertical timing counters once per tick.
- Produces registered `hsync`, `vsync`, `video_on`, pixel coordinates and line/frame markers for the pixel-generation stage.
- Default timing is 640x480 @ 60 Hz: 800 x 525 pixel ticks per frame.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- pix_en  in  1  pixel tick, one clk wide, from the clock-enable generator
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- video_on  out  1  high while in the visible region
- pixel_x  out  10  horizontal count of the current pixel
- pixel_y  out  10  vertical count of the current pixel
- line_start  out  1  one-clk pulse: first pixel of a line
- frame_start  out  1  one-clk pulse: first pixel of a frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the four H parameters (800).
  - V_TOTAL = sum of the four V parameters (525).
  - Both totals must be ≤ 1024; an elaboration-time check fails otherwise.
- Internal counters h_cnt and v_cnt are 10 bits; both reset to 0.
- Counter update happens only on clk edges where pix_en=1:
  - h_cnt increments.
  - When h_cnt = H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt = V_TOTAL-1 at the same time as the h_cnt wrap, v_cnt wraps to 0.
- When pix_en=0, counters and all level outputs hold.
- Outputs are registered and updated on the same pix_en edge from the pre-increment counter values. Outputs therefore lag the counters by exactly one pixel tick.
  - pixel_x = h_cnt; pixel_y = v_cnt. Raw counts are also driven during blanking; consumers gate with video_on.
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync = SYNC_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751] by default); otherwise ~SYNC_POL.
  - vsync = SYNC_POL when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491] by default); otherwise ~SYNC_POL. vsync is decoded from v_cnt alone, so it changes at line boundaries.
  - line_start = 1 when h_cnt=0. frame_start = 1 when h_cnt=0 and v_cnt=0.
  - Both pulses are cleared on the next clk edge whatever pix_en is, so they are always exactly one clk wide.
- Reset values (asynchronous): hsync=~SYNC_POL, vsync=~SYNC_POL, video_on=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
- First pix_en after reset: outputs load the decode of (0,0), giving video_on=1, line_start=1, frame_start=1.
- Reset mid-frame: all state returns immediately to reset values. The first subsequent tick starts a fresh frame.
- pix_en held high every clk is legal; the timing then runs at the clk rate. No duty-cycle assumption is made.

Decomposition:
- Shared package `vga_timing_pkg`:
  - Default 640x480@60 timing constants (H/V active, porches, sync widths, totals).
  - Counter width constant 10.
  - Sync polarity constant.
- One natural sub-module: `vga_axis_counter`, instantiated twice (horizontal, vertical).
  - Parameterised on active/fp/sync/bp.
  - Inputs: enable and wrap-carry-in. Outputs: count, carry-out on wrap, in_active, in_sync.
  - The vertical instance's enable = pix_en && horizontal carry-out.

Test Plan:
- Reset then one pix_en → pixel_x=0, pixel_y=0, video_on=1, hsync=1, vsync=1, line_start and frame_start high for exactly one clk.
- pix_en every 2nd clk for one line → video_on falls after tick 640; hsync low for ticks 656..751 (96 ticks); line_start recurs every 800 ticks (1600 clks).
- Run a full frame → vsync low only while pixel_y in {490,491} (1600 ticks); frame_start period 420000 ticks; pixel_y wraps 524→0 together with pixel_x 799→0.
- Irregular pix_en with gaps of 0–5 clks → outputs frozen during gaps; tick count between hsync falling edges still 800; pulses never wider than one clk.
- Assert rst_n low at pixel (300,200) → outputs return to reset values asynchronously; the first tick after release gives frame_start=1 with pixel (0,0).
- pix_en tied high → identical sequence, with one-clk granularity: frame_start every 420000 clks.
